// File: rtl/spi_tx_sequencer_if.sv
// SPI master handshake bundle between spi_tx_sequencer and the 16-bit SPI master.
// master modport: sequencer side; slave modport: SPI master side.
interface spi_tx_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              start_transfer;
  logic [DATA_W-1:0] data_to_tx;
  logic [DATA_W-1:0] data_rx;
  logic              transfer_done;
  logic              transfer_busy;

  modport master (
    output start_transfer,
    output data_to_tx,
    input  data_rx,
    input  transfer_done,
    input  transfer_busy
  );

  modport slave (
    input  start_transfer,
    input  data_to_tx,
    output data_rx,
    output transfer_done,
    output transfer_busy
  );
endinterface

// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: TX word FIFO feeding the SPI master one word at a time,
// returning each received word with a one-cycle rx_valid strobe.
// Optional slave echo check enabled by defining SPI_SEQ_ECHO_CHECK_EN.
module spi_tx_sequencer #(
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              seq_busy,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              overflow,
  output logic              start_timeout,
  output logic              echo_error,
  spi_tx_sequencer_if.master spi
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, XFER, GAP} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] tx_word;
  logic              push, pop, start_q, capture, timeout_evt;
  logic              timeout_hit, gap_done;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign push        = wr_en && !full;
  assign timeout_hit = (cnt == CW'(START_TIMEOUT - 1));
  assign gap_done    = (GAP_CYCLES == 0) || (cnt == CW'(GAP_CYCLES - 1));

  assign spi.start_transfer = start_q;
  assign spi.data_to_tx     = tx_word;

  // FIFO storage; contents are don't-care after reset since pointers clear
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; IDLE also reacts to a same-cycle write so LOAD follows the write directly
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty || push) state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (spi.transfer_busy) state_next = XFER;
               else if (timeout_hit)  state_next = GAP;
      XFER:    if (spi.transfer_done) state_next = GAP;
      GAP:     if (gap_done) state_next = empty ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and internal strobes
  always_comb begin
    start_q     = (state == START);
    seq_busy    = (state != IDLE);
    pop         = (state == LOAD);
    capture     = (state == XFER) && spi.transfer_done;
    timeout_evt = (state == START) && !spi.transfer_busy && timeout_hit;
  end

  // Datapath: wait counter, outgoing word, received word, timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      tx_word       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      start_timeout <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != state_next)                 cnt <= '0;
      else if (state == START || state == GAP) cnt <= cnt + 1'b1;
      if (pop)         tx_word       <= mem[rd_ptr];
      if (timeout_evt) start_timeout <= 1'b1;
      if (capture) begin
        rx_data  <= spi.data_rx;
        rx_valid <= 1'b1;
      end
    end
  end

`ifdef SPI_SEQ_ECHO_CHECK_EN
  logic [DATA_W-1:0] echo_ref;
  logic              echo_armed;

  // Echo check: each capture is compared against the previously transferred word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_ref   <= '0;
      echo_armed <= 1'b0;
      echo_error <= 1'b0;
    end else if (capture) begin
      if (echo_armed && (spi.data_rx != echo_ref)) echo_error <= 1'b1;
      echo_ref   <= tx_word;
      echo_armed <= 1'b1;
    end else if (timeout_evt) begin
      echo_armed <= 1'b0;
    end
  end
`else
  assign echo_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer (DEPTH=8, GAP_CYCLES=4, START_TIMEOUT=255).
module tb_spi_tx_sequencer;
  localparam int DW   = 16;
  localparam int GAPC = 4;
  localparam int TOUT = 255;
`ifdef SPI_SEQ_ECHO_CHECK_EN
  localparam logic ECHO_ON = 1'b1;
`else
  localparam logic ECHO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr_en;
  logic [DW-1:0] wr_data;
  logic          full, empty, seq_busy, rx_valid, overflow, start_timeout, echo_error;
  logic [DW-1:0] rx_data;

  logic          model_busy, model_done, man_busy, man_done, slave_en;
  logic [DW-1:0] model_rx, man_rx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rx_seen  = 0;
  int done_cyc = 0;
  logic expect_b2b;

  logic [DW-1:0] tx_exp_q[$];
  logic [DW-1:0] rx_exp_q[$];
  logic [DW-1:0] rsp_q[$];

  typedef struct {
    logic          wr;
    logic [DW-1:0] data;
    logic          acc;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_ovf;
  } vec_t;
  vec_t vec[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_tx_sequencer_if #(.DATA_W(DW)) spi_bus ();

  assign spi_bus.transfer_busy = model_busy | man_busy;
  assign spi_bus.transfer_done = model_done | man_done;
  assign spi_bus.data_rx       = man_done ? man_rx : model_rx;

  spi_tx_sequencer #(
    .DATA_W(DW), .DEPTH(8), .GAP_CYCLES(GAPC), .START_TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .seq_busy(seq_busy), .rx_valid(rx_valid),
    .rx_data(rx_data), .overflow(overflow), .start_timeout(start_timeout),
    .echo_error(echo_error), .spi(spi_bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit track);
    wr_en = 1'b1; wr_data = d;
    if (track) tx_exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while ((seq_busy || !empty) && n < lim) begin tick(); n++; end
    chk(nm, 32'(n < lim), 32'd1);
  endtask

  task automatic wait_start(input string nm, input int lim);
    int n = 0;
    while (!spi_bus.start_transfer && n < lim) begin tick(); n++; end
    chk(nm, 32'(n < lim), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  // Receive scoreboard: every rx_valid pops the word the model master returned
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_seen++;
      if (rx_exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else                      chk("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
    end
  end

  // Model SPI master: busy 3 cycles after start, busy for 4 cycles, then a done pulse
  initial begin : master_model
    int            n_rsp;
    logic [DW-1:0] rsp;
    n_rsp = 0;
    model_busy = 1'b0; model_done = 1'b0; model_rx = '0; expect_b2b = 1'b0;
    forever begin
      tick();
      if (slave_en && spi_bus.start_transfer) begin
        if (expect_b2b) chk("b2b_gap", 32'(cyc - done_cyc), 32'(GAPC + 2));
        expect_b2b = 1'b0;
        if (tx_exp_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_word", 32'(spi_bus.data_to_tx), 32'(tx_exp_q.pop_front()));
        repeat (3) tick();
        model_busy = 1'b1;
        repeat (4) tick();
        model_busy = 1'b0;
        if (rsp_q.size() != 0) rsp = rsp_q.pop_front();
        else begin rsp = DW'(16'hC000 + n_rsp); n_rsp++; end
        model_rx = rsp; model_done = 1'b1;
        rx_exp_q.push_back(rsp);
        done_cyc   = cyc;
        expect_b2b = !empty;
        tick();
        model_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, base;
    for (int i = 0; i < 10; i++) begin
      vec[i].wr        = 1'b1;
      vec[i].data      = DW'(16'h0100 + i);
      vec[i].acc       = (i < 9);
      vec[i].exp_full  = (i >= 8);
      vec[i].exp_empty = 1'b0;
      vec[i].exp_ovf   = (i == 9);
    end

    reset = 1'b1; wr_en = 1'b0; wr_data = '0;
    man_busy = 1'b0; man_done = 1'b0; man_rx = '0; slave_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset values
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_start_timeout", 32'(start_timeout), 32'd0);
    chk("rst_echo_error", 32'(echo_error), 32'd0);
    chk("rst_start", 32'(spi_bus.start_transfer), 32'd0);
    chk("rst_data_to_tx", 32'(spi_bus.data_to_tx), 32'd0);

    // single word while idle
    slave_en = 1'b1;
    rsp_q.push_back(16'hA5A5);
    base = rx_seen;
    wr(16'h0019, 1'b1);
    chk("t1_empty_fall", 32'(empty), 32'd0);
    chk("t1_busy", 32'(seq_busy), 32'd1);
    chk("t1_start_early", 32'(spi_bus.start_transfer), 32'd0);
    tick();
    chk("t1_start_rise", 32'(spi_bus.start_transfer), 32'd1);
    chk("t1_data_to_tx", 32'(spi_bus.data_to_tx), 32'h0019);
    repeat (3) tick();
    chk("t1_start_hold", 32'(spi_bus.start_transfer), 32'd1);
    tick();
    chk("t1_start_drop", 32'(spi_bus.start_transfer), 32'd0);
    wait_idle("t1_idle_timeout", 200);
    chk("t1_rx_count", 32'(rx_seen - base), 32'd1);
    chk("t1_empty_end", 32'(empty), 32'd1);
    chk("t1_rx_data_held", 32'(rx_data), 32'hA5A5);

    // fill FIFO with no master response, then drain in order
    slave_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = vec[i].wr; wr_data = vec[i].data;
      if (vec[i].acc) tx_exp_q.push_back(vec[i].data);
      tick();
      wr_en = 1'b0;
      chk($sformatf("fill_full_%0d", i), 32'(full), 32'(vec[i].exp_full));
      chk($sformatf("fill_empty_%0d", i), 32'(empty), 32'(vec[i].exp_empty));
      chk($sformatf("fill_ovf_%0d", i), 32'(overflow), 32'(vec[i].exp_ovf));
    end
    slave_en = 1'b1;
    wait_idle("t2_drain_timeout", 3000);
    chk("t2_tx_all_sent", 32'(tx_exp_q.size()), 32'd0);
    chk("t2_rx_all_seen", 32'(rx_exp_q.size()), 32'd0);
    chk("t2_overflow_sticky", 32'(overflow), 32'd1);

    // start timeout: first word discarded, second proceeds
    slave_en = 1'b0;
    wr(16'h7001, 1'b1);
    wr(16'h7002, 1'b1);
    wait_start("t3_start_seen", 20);
    n = 0;
    while (spi_bus.start_transfer && n < 400) begin tick(); n++; end
    chk("t3_start_len", 32'(n), 32'(TOUT));
    chk("t3_timeout_flag", 32'(start_timeout), 32'd1);
    void'(tx_exp_q.pop_front());
    slave_en = 1'b1;
    wait_idle("t3_idle_timeout", 500);
    chk("t3_tx_all_sent", 32'(tx_exp_q.size()), 32'd0);
    chk("t3_timeout_sticky", 32'(start_timeout), 32'd1);

    // echo sequence
    pulse_reset();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    chk("t4_timeout_cleared", 32'(start_timeout), 32'd0);
    rsp_q.push_back(16'h0000);
    rsp_q.push_back(16'h1111);
    rsp_q.push_back(16'h9999);
    base = rx_seen;
    wr(16'h1111, 1'b1);
    wr(16'h2222, 1'b1);
    wr(16'h3333, 1'b1);
    n = 0;
    while (rx_seen < base + 2 && n < 500) begin tick(); n++; end
    chk("t4_two_rx", 32'(n < 500), 32'd1);
    chk("t4_echo_ok", 32'(echo_error), 32'd0);
    n = 0;
    while (rx_seen < base + 3 && n < 500) begin tick(); n++; end
    chk("t4_three_rx", 32'(n < 500), 32'd1);
    chk("t4_echo_third", 32'(echo_error), 32'(ECHO_ON));
    wait_idle("t4_idle_timeout", 200);
    chk("t4_echo_sticky", 32'(echo_error), 32'(ECHO_ON));

    // reset during XFER
    slave_en = 1'b0;
    base = rx_seen;
    wr(16'h4001, 1'b0);
    wr(16'h4002, 1'b0);
    wr(16'h4003, 1'b0);
    wait_start("t5_start_seen", 20);
    man_busy = 1'b1; tick(); man_busy = 1'b0;
    chk("t5_in_xfer_start", 32'(spi_bus.start_transfer), 32'd0);
    chk("t5_in_xfer_busy", 32'(seq_busy), 32'd1);
    tick();
    reset = 1'b1; #1;
    chk("t5_rst_start", 32'(spi_bus.start_transfer), 32'd0);
    chk("t5_rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_echo", 32'(echo_error), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    man_rx = 16'hDEAD; man_done = 1'b1; tick(); man_done = 1'b0;
    repeat (3) tick();
    chk("t5_no_rx_after_reset", 32'(rx_seen - base), 32'd0);
    chk("t5_idle_after_done", 32'(seq_busy), 32'd0);
    chk("t5_rx_data_reset", 32'(rx_data), 32'd0);

    chk("end_rx_queue", 32'(rx_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
